multicycle_control_unit: RTL and testbench

Sequencing controller for the multi-cycle ARM-subset datapath; it replaces the single-cycle combinational decoder. It walks each instruction through fetch/decode/execute/writeback states and owns the architectural NZCV flag register. It evaluates all 15 ARM condition codes and issues datapath select, enable and memory-request signals each cycle. Memory accesses use a req/ready handshake, so instruction and data memories may take any number of cycles.

---
 rtl/ctrl_pkg.sv | 85 ++++++++
 rtl/cond_check.sv | 36 +++
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle ARM-subset control unit: FSM states,
// condition codes, datapath select encodings and instruction field constants.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_LINK   = 4'd9,
      S_BRANCH = 4'd10
   } state_t;

   // ARM condition codes
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // alu_control
   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_ORR   = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;

   // alu_src_b
   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // imm_src
   localparam logic [1:0] IMM_ROT8  = 2'b00;
   localparam logic [1:0] IMM_12    = 2'b01;
   localparam logic [1:0] IMM_24    = 2'b10;

   // result_src
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_PC     = 2'b11;

   // op field instr[27:26]
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // cmd field instr[24:21]
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   // ALU operation for a data-processing cmd; CMP is a SUB whose result is discarded
   function automatic logic [2:0] cmd_to_alu(input logic [3:0] cmd);
      case (cmd)
         CMD_ADD:          cmd_to_alu = ALU_ADD;
         CMD_SUB, CMD_CMP: cmd_to_alu = ALU_SUB;
         CMD_AND:          cmd_to_alu = ALU_AND;
         CMD_ORR:          cmd_to_alu = ALU_ORR;
         CMD_MOV:          cmd_to_alu = ALU_PASSB;
         default:          cmd_to_alu = ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition evaluation against NZCV; NV (1111) never passes.
module cond_check
   import ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic w_n, w_z, w_c, w_v;
   assign {w_n, w_z, w_c, w_v} = nzcv;

   // Pure lookup of the 16 condition encodings
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = w_z;
         COND_NE: pass = ~w_z;
         COND_CS: pass = w_c;
         COND_CC: pass = ~w_c;
         COND_MI: pass = w_n;
         COND_PL: pass = ~w_n;
         COND_VS: pass = w_v;
         COND_VC: pass = ~w_v;
         COND_HI: pass = w_c & ~w_z;
         COND_LS: pass = ~w_c | w_z;
         COND_GE: pass = (w_n == w_v);
         COND_LT: pass = (w_n != w_v);
         COND_GT: pass = ~w_z & (w_n == w_v);
         COND_LE: pass = w_z | (w_n != w_v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FSM state register, NZCV flag register, next-state
// logic and per-state datapath control decode. Memory uses req/ready.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter logic ENABLE_BL    = 1'b1,
   parameter logic ENABLE_LOGIC = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instr,
   input  logic [3:0]  alu_flags,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_write,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic        adr_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  imm_src,
   output logic [2:0]  alu_control,
   output logic [1:0]  result_src,
   output logic [1:0]  reg_src,
   output logic        wa_lr,
   output logic [3:0]  flags,
   output logic [3:0]  state
);

   state_t     r_state, w_next;
   logic [3:0] r_flags;

   logic [1:0] w_op;
   logic [3:0] w_cmd;
   logic       w_cond_pass, w_cmd_ok, w_cmd_logic;
   logic       w_mreq, w_mwr, w_pcw, w_irw, w_rgw, w_adr, w_srca, w_walr;
   logic [1:0] w_srcb, w_imm, w_res, w_rsrc;
   logic [2:0] w_alu;
   logic       w_flag_all, w_flag_nz;

   assign w_op  = instr[27:26];
   assign w_cmd = instr[24:21];

   // DECODE always looks at the architectural flags, never the live ALU flags
   cond_check u_cond (
      .cond (instr[31:28]),
      .nzcv (r_flags),
      .pass (w_cond_pass)
   );

   // Supported data-processing commands; logic ops drop out when disabled
   always_comb begin
      w_cmd_ok    = 1'b0;
      w_cmd_logic = 1'b0;
      case (w_cmd)
         CMD_ADD, CMD_SUB, CMD_CMP: w_cmd_ok = 1'b1;
         CMD_MOV:                   begin w_cmd_ok = 1'b1; w_cmd_logic = 1'b1; end
         CMD_AND, CMD_ORR:          begin w_cmd_ok = ENABLE_LOGIC; w_cmd_logic = 1'b1; end
         default:                   w_cmd_ok = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_FETCH;
      else          r_state <= w_next;
   end

   // Flags register: arithmetic loads NZCV, logic/MOV loads only N,Z
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_flags      <= 4'b0000;
      else if (w_flag_all) r_flags      <= alu_flags;
      else if (w_flag_nz)  r_flags[3:2] <= alu_flags[3:2];
   end

   // Next-state and raw control decode per state
   always_comb begin
      w_next     = r_state;
      w_mreq     = 1'b0;
      w_mwr      = 1'b0;
      w_pcw      = 1'b0;
      w_irw      = 1'b0;
      w_rgw      = 1'b0;
      w_adr      = 1'b0;
      w_srca     = 1'b0;
      w_srcb     = SRCB_RD2;
      w_imm      = IMM_ROT8;
      w_alu      = ALU_ADD;
      w_res      = RES_ALUOUT;
      w_rsrc     = 2'b00;
      w_walr     = 1'b0;
      w_flag_all = 1'b0;
      w_flag_nz  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mreq = 1'b1;
            w_srca = 1'b1;
            w_srcb = SRCB_FOUR;
            w_res  = RES_ALURES;
            if (mem_ready) begin
               w_pcw  = 1'b1;
               w_irw  = 1'b1;
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            w_next = S_FETCH;
            if (w_cond_pass) begin
               case (w_op)
                  OP_MEM: w_next = S_MEMADR;
                  OP_DP:  if (w_cmd_ok) w_next = instr[25] ? S_EXECI : S_EXECR;
                  OP_BR:  w_next = (ENABLE_BL && instr[24]) ? S_LINK : S_BRANCH;
                  default: w_next = S_FETCH;
               endcase
            end
         end
         S_MEMADR: begin
            w_srcb = SRCB_IMM;
            w_imm  = IMM_12;
            w_alu  = instr[23] ? ALU_ADD : ALU_SUB;
            w_next = instr[20] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_mreq = 1'b1;
            w_adr  = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_rgw  = 1'b1;
            w_res  = RES_RDATA;
            w_next = S_FETCH;
         end
         S_MEMWR: begin
            w_mreq = 1'b1;
            w_mwr  = 1'b1;
            w_adr  = 1'b1;
            w_rsrc = 2'b10;
            if (mem_ready) w_next = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            w_srcb = (r_state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
            w_alu  = cmd_to_alu(w_cmd);
            if (instr[20] || w_cmd == CMD_CMP) begin
               w_flag_all = ~w_cmd_logic;
               w_flag_nz  = w_cmd_logic;
            end
            w_next = (w_cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
         end
         S_ALUWB: begin
            w_rgw  = 1'b1;
            w_next = S_FETCH;
         end
         S_LINK: begin
            w_rgw  = 1'b1;
            w_walr = 1'b1;
            w_res  = RES_PC;
            w_next = S_BRANCH;
         end
         S_BRANCH: begin
            w_srca = 1'b1;
            w_srcb = SRCB_IMM;
            w_imm  = IMM_24;
            w_res  = RES_ALURES;
            w_pcw  = 1'b1;
            w_next = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Reset masks controls combinationally so an in-flight request drops at once
   assign mem_req     = reset_n & w_mreq;
   assign mem_write   = reset_n & w_mwr;
   assign pc_write    = reset_n & w_pcw;
   assign ir_write    = reset_n & w_irw;
   assign reg_write   = reset_n & w_rgw;
   assign adr_src     = reset_n & w_adr;
   assign alu_src_a   = reset_n & w_srca;
   assign wa_lr       = reset_n & w_walr;
   assign alu_src_b   = reset_n ? w_srcb : 2'b00;
   assign imm_src     = reset_n ? w_imm  : 2'b00;
   assign alu_control = reset_n ? w_alu  : 3'b000;
   assign result_src  = reset_n ? w_res  : 2'b00;
   assign reg_src     = reset_n ? w_rsrc : 2'b00;

   assign flags = r_flags;
   assign state = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Cycle-by-cycle check of the control FSM: a table of per-cycle vectors is fed
// through a scoreboard queue, then hand sequences cover the parameter variants
// and asynchronous reset during a store stall.
module tb_multicycle_control_unit;
   import ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] instr = 32'h0;
   logic [3:0]  alu_flags = 4'h0;
   logic        mem_ready = 1'b0;

   logic       mem_req, mem_write, pc_write, ir_write, reg_write, adr_src, alu_src_a, wa_lr;
   logic [1:0] alu_src_b, imm_src, result_src, reg_src;
   logic [2:0] alu_control;
   logic [3:0] flags, state;

   logic       b_mem_req, b_mem_write, b_pc_write, b_ir_write, b_reg_write, b_adr_src, b_alu_src_a, b_wa_lr;
   logic [1:0] b_alu_src_b, b_imm_src, b_result_src, b_reg_src;
   logic [2:0] b_alu_control;
   logic [3:0] b_flags, b_state;

   multicycle_control_unit dut (
      .clk(clk), .reset_n(reset_n), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .pc_write(pc_write), .ir_write(ir_write),
      .reg_write(reg_write), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .alu_control(alu_control), .result_src(result_src), .reg_src(reg_src),
      .wa_lr(wa_lr), .flags(flags), .state(state)
   );

   multicycle_control_unit #(.ENABLE_BL(1'b0), .ENABLE_LOGIC(1'b0)) dut2 (
      .clk(clk), .reset_n(reset_n), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
      .mem_req(b_mem_req), .mem_write(b_mem_write), .pc_write(b_pc_write), .ir_write(b_ir_write),
      .reg_write(b_reg_write), .adr_src(b_adr_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
      .imm_src(b_imm_src), .alu_control(b_alu_control), .result_src(b_result_src), .reg_src(b_reg_src),
      .wa_lr(b_wa_lr), .flags(b_flags), .state(b_state)
   );

   always #5 clk = ~clk;

   logic [18:0] ctl;
   assign ctl = {mem_req, mem_write, pc_write, ir_write, reg_write, adr_src, alu_src_a,
                 alu_src_b, imm_src, alu_control, result_src, reg_src, wa_lr};

   int pass_cnt = 0;
   int total    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected control word for a state, straight from the per-state output table
   function automatic logic [18:0] ctl_model(input state_t st, input logic [31:0] ins, input logic rdy);
      logic mr, mw, pw, iw, rw, as, sa, wl;
      logic [1:0] sb, is, rs, rg;
      logic [2:0] ac;
      {mr, mw, pw, iw, rw, as, sa, wl} = 8'h0;
      sb = 2'b00; is = 2'b00; rs = 2'b00; rg = 2'b00; ac = 3'b000;
      case (st)
         S_FETCH:  begin mr = 1; sa = 1; sb = 2'b10; rs = 2'b10; pw = rdy; iw = rdy; end
         S_MEMADR: begin sb = 2'b01; is = 2'b01; ac = ins[23] ? 3'b000 : 3'b001; end
         S_MEMRD:  begin mr = 1; as = 1; end
         S_MEMWB:  begin rw = 1; rs = 2'b01; end
         S_MEMWR:  begin mr = 1; mw = 1; as = 1; rg = 2'b10; end
         S_EXECR, S_EXECI: begin
            sb = (st == S_EXECI) ? 2'b01 : 2'b00;
            case (ins[24:21])
               4'b0100:          ac = 3'b000;
               4'b0010, 4'b1010: ac = 3'b001;
               4'b1101:          ac = 3'b100;
               4'b0000:          ac = 3'b010;
               4'b1100:          ac = 3'b011;
               default:          ac = 3'b000;
            endcase
         end
         S_ALUWB:  rw = 1;
         S_LINK:   begin rw = 1; wl = 1; rs = 2'b11; end
         S_BRANCH: begin sa = 1; sb = 2'b01; is = 2'b10; pw = 1; rs = 2'b10; end
         default: ;
      endcase
      return {mr, mw, pw, iw, rw, as, sa, sb, is, ac, rs, rg, wl};
   endfunction

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  af;
      logic        rdy;
      state_t      st;
      logic [3:0]  fl;
   } vec_t;

   function automatic vec_t v(input logic [31:0] i, input logic [3:0] af, input logic r,
                              input state_t st, input logic [3:0] fl);
      vec_t x;
      x.ins = i; x.af = af; x.rdy = r; x.st = st; x.fl = fl;
      return x;
   endfunction

   localparam logic [31:0] I_ADD  = 32'hE0821003;
   localparam logic [31:0] I_SUBS = 32'hE0511002;
   localparam logic [31:0] I_BEQ  = 32'h0A000002;
   localparam logic [31:0] I_LDR  = 32'hE5912004;
   localparam logic [31:0] I_STR  = 32'hE5812004;
   localparam logic [31:0] I_ANDS = 32'hE0121003;
   localparam logic [31:0] I_ORRS = 32'hE1921003;
   localparam logic [31:0] I_CMPI = 32'hE3510005;
   localparam logic [31:0] I_BMI  = 32'h4A000001;
   localparam logic [31:0] I_BL   = 32'hEB000010;
   localparam logic [31:0] I_NV   = 32'hF0821003;

   vec_t tbl[$];
   vec_t sb[$];

   // Scoreboard consumer: compare each pushed expectation mid-cycle
   always @(negedge clk) begin
      vec_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("state", state, e.st);
         chk("ctl", ctl, ctl_model(e.st, e.ins, e.rdy));
         chk("flags", flags, e.fl);
      end
   end

   task automatic cyc(input logic [31:0] i, input logic [3:0] af, input logic r);
      @(posedge clk);
      #1 instr = i; alu_flags = af; mem_ready = r;
      #3;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1; mem_ready = 1'b0;
   endtask

   initial begin
      // ADD: flags untouched even with live ALU flags non-zero
      tbl.push_back(v(I_ADD, 4'b0110, 1, S_FETCH,  4'b0000));
      tbl.push_back(v(I_ADD, 4'b0110, 1, S_DECODE, 4'b0000));
      tbl.push_back(v(I_ADD, 4'b0110, 1, S_EXECR,  4'b0000));
      tbl.push_back(v(I_ADD, 4'b0110, 1, S_ALUWB,  4'b0000));
      // SUBS -> Z, then BEQ taken
      tbl.push_back(v(I_SUBS, 4'b0100, 1, S_FETCH,  4'b0000));
      tbl.push_back(v(I_SUBS, 4'b0100, 1, S_DECODE, 4'b0000));
      tbl.push_back(v(I_SUBS, 4'b0100, 1, S_EXECR,  4'b0000));
      tbl.push_back(v(I_SUBS, 4'b0000, 1, S_ALUWB,  4'b0100));
      tbl.push_back(v(I_BEQ,  4'b0000, 1, S_FETCH,  4'b0100));
      tbl.push_back(v(I_BEQ,  4'b0000, 1, S_DECODE, 4'b0100));
      tbl.push_back(v(I_BEQ,  4'b0000, 1, S_BRANCH, 4'b0100));
      // SUBS -> clear, then BEQ not taken
      tbl.push_back(v(I_SUBS, 4'b0000, 1, S_FETCH,  4'b0100));
      tbl.push_back(v(I_SUBS, 4'b0000, 1, S_DECODE, 4'b0100));
      tbl.push_back(v(I_SUBS, 4'b0000, 1, S_EXECR,  4'b0100));
      tbl.push_back(v(I_SUBS, 4'b0000, 1, S_ALUWB,  4'b0000));
      tbl.push_back(v(I_BEQ,  4'b0000, 1, S_FETCH,  4'b0000));
      tbl.push_back(v(I_BEQ,  4'b0000, 1, S_DECODE, 4'b0000));
      // LDR with 3 wait cycles in MEMRD; ready in DECODE is ignored
      tbl.push_back(v(I_LDR, 4'b0000, 1, S_FETCH,  4'b0000));
      tbl.push_back(v(I_LDR, 4'b0000, 1, S_DECODE, 4'b0000));
      tbl.push_back(v(I_LDR, 4'b0000, 1, S_MEMADR, 4'b0000));
      tbl.push_back(v(I_LDR, 4'b0000, 0, S_MEMRD,  4'b0000));
      tbl.push_back(v(I_LDR, 4'b0000, 0, S_MEMRD,  4'b0000));
      tbl.push_back(v(I_LDR, 4'b0000, 0, S_MEMRD,  4'b0000));
      tbl.push_back(v(I_LDR, 4'b0000, 1, S_MEMRD,  4'b0000));
      tbl.push_back(v(I_LDR, 4'b0000, 1, S_MEMWB,  4'b0000));
      // STR with a fetch stall and a store stall
      tbl.push_back(v(I_STR, 4'b0000, 0, S_FETCH,  4'b0000));
      tbl.push_back(v(I_STR, 4'b0000, 1, S_FETCH,  4'b0000));
      tbl.push_back(v(I_STR, 4'b0000, 0, S_DECODE, 4'b0000));
      tbl.push_back(v(I_STR, 4'b0000, 0, S_MEMADR, 4'b0000));
      tbl.push_back(v(I_STR, 4'b0000, 0, S_MEMWR,  4'b0000));
      tbl.push_back(v(I_STR, 4'b0000, 1, S_MEMWR,  4'b0000));
      // SUBS -> 0011, ANDS keeps C,V, ORRS keeps C,V
      tbl.push_back(v(I_SUBS, 4'b0011, 1, S_FETCH,  4'b0000));
      tbl.push_back(v(I_SUBS, 4'b0011, 1, S_DECODE, 4'b0000));
      tbl.push_back(v(I_SUBS, 4'b0011, 1, S_EXECR,  4'b0000));
      tbl.push_back(v(I_SUBS, 4'b0011, 1, S_ALUWB,  4'b0011));
      tbl.push_back(v(I_ANDS, 4'b1011, 1, S_FETCH,  4'b0011));
      tbl.push_back(v(I_ANDS, 4'b1011, 1, S_DECODE, 4'b0011));
      tbl.push_back(v(I_ANDS, 4'b1011, 1, S_EXECR,  4'b0011));
      tbl.push_back(v(I_ANDS, 4'b0000, 1, S_ALUWB,  4'b1011));
      tbl.push_back(v(I_ORRS, 4'b0100, 1, S_FETCH,  4'b1011));
      tbl.push_back(v(I_ORRS, 4'b0100, 1, S_DECODE, 4'b1011));
      tbl.push_back(v(I_ORRS, 4'b0100, 1, S_EXECR,  4'b1011));
      tbl.push_back(v(I_ORRS, 4'b0000, 1, S_ALUWB,  4'b0111));
      // CMP immediate: 3 cycles, loads all flags
      tbl.push_back(v(I_CMPI, 4'b1000, 1, S_FETCH,  4'b0111));
      tbl.push_back(v(I_CMPI, 4'b1000, 1, S_DECODE, 4'b0111));
      tbl.push_back(v(I_CMPI, 4'b1000, 1, S_EXECI,  4'b0111));
      // BMI taken on the flags CMP just wrote
      tbl.push_back(v(I_BMI, 4'b0000, 1, S_FETCH,  4'b1000));
      tbl.push_back(v(I_BMI, 4'b0000, 1, S_DECODE, 4'b1000));
      tbl.push_back(v(I_BMI, 4'b0000, 1, S_BRANCH, 4'b1000));
      // BL: LINK then BRANCH
      tbl.push_back(v(I_BL, 4'b0000, 1, S_FETCH,  4'b1000));
      tbl.push_back(v(I_BL, 4'b0000, 1, S_DECODE, 4'b1000));
      tbl.push_back(v(I_BL, 4'b0000, 1, S_LINK,   4'b1000));
      tbl.push_back(v(I_BL, 4'b0000, 1, S_BRANCH, 4'b1000));
      // NV never executes
      tbl.push_back(v(I_NV, 4'b0000, 1, S_FETCH,  4'b1000));
      tbl.push_back(v(I_NV, 4'b0000, 1, S_DECODE, 4'b1000));
      tbl.push_back(v(I_ADD, 4'b0000, 0, S_FETCH, 4'b1000));

      // Reset state: controls forced low even with mem_ready high
      mem_ready = 1'b1;
      #12;
      chk("rst_ctl", ctl, 19'h0);
      chk("rst_flags", flags, 4'b0000);
      chk("rst_state", state, S_FETCH);
      @(posedge clk);
      #1 reset_n = 1'b1; mem_ready = 1'b0;
      #3 chk("first_req", mem_req, 1'b1);

      foreach (tbl[k]) begin
         @(posedge clk);
         #1 instr = tbl[k].ins; alu_flags = tbl[k].af; mem_ready = tbl[k].rdy;
         sb.push_back(tbl[k]);
      end
      for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
      chk("sb_drained", sb.size(), 0);

      // ENABLE_BL=0: BL runs as B, LINK never entered
      do_reset();
      cyc(I_BL, 4'b0000, 1); chk("nobl_f", b_state, S_FETCH);
      cyc(I_BL, 4'b0000, 1); chk("nobl_d", b_state, S_DECODE);
      cyc(I_BL, 4'b0000, 1); chk("nobl_br", b_state, S_BRANCH);
      chk("nobl_walr", b_wa_lr, 1'b0);
      chk("nobl_pcw", b_pc_write, 1'b1);
      cyc(I_BL, 4'b0000, 0); chk("nobl_ret", b_state, S_FETCH);

      // ENABLE_LOGIC=0: ANDS is a NOP, flags stay 0011
      do_reset();
      cyc(I_SUBS, 4'b0011, 1);
      cyc(I_SUBS, 4'b0011, 1);
      cyc(I_SUBS, 4'b0011, 1); chk("nl_subs", b_state, S_EXECR);
      cyc(I_SUBS, 4'b0011, 1); chk("nl_flg0", b_flags, 4'b0011);
      cyc(I_ANDS, 4'b1011, 1); chk("nl_f", b_state, S_FETCH);
      cyc(I_ANDS, 4'b1011, 1); chk("nl_d", b_state, S_DECODE);
      cyc(I_ANDS, 4'b1011, 1); chk("nl_nop", b_state, S_FETCH);
      chk("nl_rgw", b_reg_write, 1'b0);
      chk("nl_flg1", b_flags, 4'b0011);

      // Async reset during a store stall
      do_reset();
      cyc(I_SUBS, 4'b0101, 1);
      cyc(I_SUBS, 4'b0101, 1);
      cyc(I_SUBS, 4'b0101, 1);
      cyc(I_SUBS, 4'b0000, 1); chk("ar_flags", flags, 4'b0101);
      cyc(I_STR, 4'b0000, 1);
      cyc(I_STR, 4'b0000, 0);
      cyc(I_STR, 4'b0000, 0);
      cyc(I_STR, 4'b0000, 0); chk("ar_wr", {mem_req, mem_write, state}, {2'b11, 4'(S_MEMWR)});
      reset_n = 1'b0;
      #1;
      chk("ar_req", mem_req, 1'b0);
      chk("ar_mw", mem_write, 1'b0);
      chk("ar_st", state, S_FETCH);
      chk("ar_fl", flags, 4'b0000);
      @(posedge clk);
      #1 reset_n = 1'b1;
      #3;
      chk("ar_post", {state, flags, mem_req}, {4'(S_FETCH), 4'b0000, 1'b1});

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
